cacheline_adaptor: RTL
======================

Name: cacheline_adaptor

Overview:
- Sits directly downstream of the memory arbiter. Converts single 256-bit line read/write requests (instruction read, data read, data write) into 4-beat 64-bit bursts on the physical-memory port.
- Returns the assembled line to the arbiter together with a one-cycle response pulse.
- One transaction in flight at a time.

Parameters:
- LINE_W, 256, cacheline width in bits
- BURST_W, 64, memory beat width; LINE_W/BURST_W = 4 beats, power of two required

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- inst_read  in  1  arbiter instruction-line read request (level, held until resp_o)
- data_read  in  1  arbiter data-line read request
- data_write  in  1  arbiter data-line write request
- inst_addr  in  32  instruction line address
- data_addr  in  32  data line address
- data_wdata  in  LINE_W  line to write
- cacheline_output  out  LINE_W  assembled read line
- resp_o  out  1  one-cycle completion pulse to arbiter
- burst_i  in  BURST_W  memory read beat
- resp_i  in  1  memory beat valid/accepted
- burst_o  out  BURST_W  memory write beat
- address_o  out  32  line-aligned memory address
- read_o  out  1  memory burst read request
- write_o  out  1  memory burst write request

Behaviour:
- Reset values: state IDLE, beat count 0, line buffer 0, address register 0. Outputs: cacheline_output 0, resp_o 0, read_o 0, write_o 0, burst_o 0, address_o 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE: the request is sampled each cycle, with priority data_write > data_read > inst_read.
  - On a request, latch address = selected addr with bits [4:0] forced to 0.
  - On data_write, also latch data_wdata into the line buffer.
  - Clear the beat count. Go to READ or WRITE on the next edge.
- READ:
  - read_o=1 and address_o=latched address (both decoded from registered state, so no combinational path from request inputs).
  - Each cycle with resp_i=1: line buffer beat[count] <= burst_i, i.e. bits [64*count+63 : 64*count]; count++.
  - On the 4th beat (count==3 && resp_i): go to DONE; count wraps to 0.
- WRITE:
  - write_o=1, address_o=latched address, burst_o=line buffer beat[count].
  - Each resp_i advances count. The 4th beat goes to DONE.
- DONE:
  - resp_o=1 for exactly this one cycle; read_o=write_o=0. Next state IDLE unconditionally.
  - Requests still asserted during DONE are ignored (the arbiter drops its request the cycle after resp_o).
- cacheline_output is driven from the line buffer.
  - It is valid during DONE and stays stable until the next read transaction captures its first beat.
  - For a write transaction, the value is unspecified.
- Latency:
  - A request sampled in IDLE at edge N gives read_o/write_o high from cycle N+1.
  - If resp_i beats arrive at cycles k..k+3 (gaps allowed), resp_o is high in cycle k+4.
  - Best case is 6 cycles from request to resp_o.
- Boundary conditions:
  - resp_i while IDLE or DONE: ignored, no state or buffer change.
  - Request deasserted or changed mid-burst: the transaction completes with the latched address and data. A memory burst is never aborted.
  - Non-aligned address input: low 5 bits are zeroed on address_o.
  - Simultaneous inst_read and data_write in IDLE: the write is served first. inst_read is served after returning to IDLE if it is still held.
  - rst asserted mid-burst: the next edge forces all reset values. read_o/write_o drop in the following cycle, and resp_o is never issued for the aborted transaction.
  - Back-to-back transactions: at least one IDLE cycle separates DONE from the next READ/WRITE.

Test Plan:
- Data read at data_addr=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> address_o=0x0000_1220, read_o held 4 cycles. resp_o pulses once with cacheline_output = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Data write of line {D3,D2,D1,D0} at 0x8000_0040, resp_i with 2-cycle gaps between beats -> burst_o = D0,D1,D2,D3 in order, write_o deasserts in the cycle after the 4th resp_i, resp_o one cycle.
- inst_read and data_write asserted together at IDLE -> write transaction first. After its resp_o, inst_read is served at inst_addr with read_o.
- resp_i pulsed while IDLE, then instruction read -> no resp_o from the spurious pulse. The line contains only the 4 beats received during READ.
- rst asserted after 2 read beats -> read_o=0 and resp_o=0 next cycle, cacheline_output=0. A subsequent fresh read completes normally.
- Request dropped after 1 beat -> remaining 3 beats still consumed, resp_o pulses once, then IDLE with no new transaction.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one LINE_W-bit line request from the arbiter into
// a burst of BURST_W-bit beats on the physical-memory port. It assembles read
// beats into a line and returns that line with a single-cycle resp_o pulse.
// Only one transaction is in flight at a time.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_read,
  input  logic               data_read,
  input  logic               data_write,
  input  logic [31:0]        inst_addr,
  input  logic [31:0]        data_addr,
  input  logic [LINE_W-1:0]  data_wdata,
  output logic [LINE_W-1:0]  cacheline_output,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg;
  logic [LINE_W-1:0]  line_reg;
  logic [31:0]        addr_reg;
  logic [BURST_W-1:0] beats [BEATS];
  logic               last_beat;

  // Present the line buffer as an array of beats so the write path can pick
  // the current beat with a plain index.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beats[gi] = line_reg[gi*BURST_W +: BURST_W];
    end
  endgenerate

  assign last_beat = resp_i && (count_reg == CNT_W'(BEATS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. Requests are looked at only in IDLE, and the priority
  // is write, then data read, then instruction read.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (data_write)                  state_next = WRITE;
        else if (data_read || inst_read) state_next = READ;
      end
      READ:    if (last_beat) state_next = DONE;
      WRITE:   if (last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. The address and write line are latched when the request is
  // accepted, so a request that changes mid-burst has no effect. Read beats
  // overwrite the buffer in place, which keeps the previous line visible
  // until the first new beat arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      line_reg  <= '0;
      addr_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          count_reg <= '0;
          if (data_write) begin
            addr_reg <= data_addr & ~32'h1F;
            line_reg <= data_wdata;
          end else if (data_read) begin
            addr_reg <= data_addr & ~32'h1F;
          end else if (inst_read) begin
            addr_reg <= inst_addr & ~32'h1F;
          end
        end
        READ: begin
          if (resp_i) begin
            for (int i = 0; i < BEATS; i++) begin
              if (count_reg == CNT_W'(i)) line_reg[i*BURST_W +: BURST_W] <= burst_i;
            end
            count_reg <= count_reg + 1'b1;
          end
        end
        WRITE: begin
          if (resp_i) count_reg <= count_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from registered state only, so the request inputs
  // never reach the memory port combinationally.
  always_comb begin
    read_o           = (state_reg == READ);
    write_o          = (state_reg == WRITE);
    resp_o           = (state_reg == DONE);
    address_o        = addr_reg;
    cacheline_output = line_reg;
    burst_o          = '0;
    if (state_reg == WRITE) burst_o = beats[count_reg];
  end

endmodule
